// File: rtl/tinyalu_responder.sv
// tinyalu_responder
// Responder end of the TinyALU start/done protocol. Accepts an operation
// when start is high in IDLE, computes add/and/xor in one cycle and
// multiply after MUL_LATENCY cycles, then pulses done for one cycle and
// waits for start to drop before accepting the next request.
//
// Parameters:
//   MUL_LATENCY  cycles from accepting mul_op to done (legal 1..8)
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous reset, active-high
//   A, B      8-bit unsigned operands
//   op        3-bit opcode (001 add, 010 and, 011 xor, 100 mul; others ignored)
//   start     operation request, held high by the initiator until done
//   done      one-cycle completion pulse
//   result    16-bit result, held until the next done
//   op_count  completed-operation counter (only with TINYALU_OPCNT_EN)
//
// Optional feature macro: TINYALU_OPCNT_EN adds the op_count output.
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | no operation in progress, waiting for start
// BUSY_MUL | multiply in progress, counter running down
// WAIT_LOW | operation finished, waiting for start to drop

module tinyalu_responder #(
   parameter int MUL_LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   input  logic [2:0]  op,
   input  logic        start,
   output logic        done,
`ifdef TINYALU_OPCNT_EN
   output logic [15:0] op_count,
`endif
   output logic [15:0] result
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_MUL = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   // Counter holds MUL_LATENCY-1 at most, so 3 bits cover the legal range.
   localparam logic [2:0] MUL_LOAD = 3'(MUL_LATENCY - 1);

   state_t      state, state_next;
   logic [2:0]  cnt, cnt_next;
   logic [7:0]  a_q, a_next;
   logic [7:0]  b_q, b_next;
   logic [15:0] result_next;
   logic        done_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 3'd0;
         a_q    <= 8'd0;
         b_q    <= 8'd0;
         result <= 16'h0000;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         a_q    <= a_next;
         b_q    <= b_next;
         result <= result_next;
         done   <= done_next;
      end
   end

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      a_next      = a_q;
      b_next      = b_q;
      result_next = result;
      done_next   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_ADD: begin
                     result_next = 16'(A) + 16'(B);
                     done_next   = 1'b1;
                     state_next  = WAIT_LOW;
                  end
                  OP_AND: begin
                     result_next = {8'h00, A & B};
                     done_next   = 1'b1;
                     state_next  = WAIT_LOW;
                  end
                  OP_XOR: begin
                     result_next = {8'h00, A ^ B};
                     done_next   = 1'b1;
                     state_next  = WAIT_LOW;
                  end
                  OP_MUL: begin
                     a_next = A;
                     b_next = B;
                     if (MUL_LATENCY == 1) begin
                        result_next = 16'(A) * 16'(B);
                        done_next   = 1'b1;
                        state_next  = WAIT_LOW;
                     end else begin
                        cnt_next   = MUL_LOAD;
                        state_next = BUSY_MUL;
                     end
                  end
                  default: ;
               endcase
            end
         end
         BUSY_MUL: begin
            // Counter reaching zero on this edge completes the multiply.
            if (cnt == 3'd1) begin
               cnt_next    = 3'd0;
               result_next = 16'(a_q) * 16'(b_q);
               done_next   = 1'b1;
               state_next  = WAIT_LOW;
            end else begin
               cnt_next = cnt - 3'd1;
            end
         end
         WAIT_LOW: begin
            if (!start) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef TINYALU_OPCNT_EN
   // Counts on the edge that raises done, so op_count updates with the pulse.
   always_ff @(posedge clk) begin
      if (reset) op_count <= 16'h0000;
      else if (done_next) op_count <= op_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_tinyalu_responder.sv
module tb_tinyalu_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  A, B;
   logic [2:0]  op;
   logic        start;
   logic        done;
   logic [15:0] result;
`ifdef TINYALU_OPCNT_EN
   logic [15:0] op_count;
`endif

   int total = 0;
   int bad   = 0;

   tinyalu_responder #(.MUL_LATENCY(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .A        (A),
      .B        (B),
      .op       (op),
      .start    (start),
      .done     (done),
`ifdef TINYALU_OPCNT_EN
      .op_count (op_count),
`endif
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; A = 8'h00; B = 8'h00; op = 3'b000; start = 1'b0;
      tick(); tick();
      check("rst_done", 16'(done), 16'd0);
      check("rst_result", result, 16'h0000);
`ifdef TINYALU_OPCNT_EN
      check("rst_opcnt", op_count, 16'd0);
`endif
      reset = 1'b0;

      // single-cycle add, boundary carry into bit 8
      A = 8'hFF; B = 8'h01; op = 3'b001; start = 1'b1;
      tick();
      check("add_done", 16'(done), 16'd1);
      check("add_result", result, 16'h0100);
      tick();
      check("add_done_low", 16'(done), 16'd0);
      check("add_result_hold", result, 16'h0100);
      start = 1'b0;
      tick();

      // multiply latency 3, operands changed mid-operation
      A = 8'hFF; B = 8'hFF; op = 3'b100; start = 1'b1;
      tick();
      check("mul_k", 16'(done), 16'd0);
      A = 8'h00; B = 8'h00;
      tick();
      check("mul_k1", 16'(done), 16'd0);
      tick();
      check("mul_k2_done", 16'(done), 16'd1);
      check("mul_result", result, 16'hFE01);
      tick();
      check("mul_done_low", 16'(done), 16'd0);
      start = 1'b0;
      tick();

      // and / xor back-to-back with one low edge between
      A = 8'hF0; B = 8'h3C; op = 3'b010; start = 1'b1;
      tick();
      check("and_done", 16'(done), 16'd1);
      check("and_result", result, 16'h0030);
      start = 1'b0;
      tick();
      check("and_done_low", 16'(done), 16'd0);
      op = 3'b011; start = 1'b1;
      tick();
      check("xor_done", 16'(done), 16'd1);
      check("xor_result", result, 16'h00CC);
      start = 1'b0;
      tick();

      // start held high after done must not retrigger
      A = 8'd3; B = 8'd4; op = 3'b001; start = 1'b1;
      tick();
      check("hold_done", 16'(done), 16'd1);
      check("hold_result", result, 16'h0007);
      for (int i = 0; i < 5; i++) begin
         A = 8'd1; B = 8'd1;
         tick();
         check("hold_no_retrigger", 16'(done), 16'd0);
      end
      check("hold_result_kept", result, 16'h0007);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      check("reaccept_done", 16'(done), 16'd1);
      check("reaccept_result", result, 16'h0002);
      start = 1'b0;
      tick();

      // no_op and unused opcodes
      A = 8'h55; B = 8'hAA; start = 1'b1;
      op = 3'b000; tick();
      check("noop_done", 16'(done), 16'd0);
      check("noop_result", result, 16'h0002);
      op = 3'b101; tick();
      check("op101_done", 16'(done), 16'd0);
      op = 3'b110; tick();
      check("op110_done", 16'(done), 16'd0);
      check("op110_result", result, 16'h0002);
      start = 1'b0;
      tick();

      // reset mid-multiply
      A = 8'd2; B = 8'd3; op = 3'b100; start = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      check("abort_done", 16'(done), 16'd0);
      check("abort_result", result, 16'h0000);
`ifdef TINYALU_OPCNT_EN
      check("abort_opcnt", op_count, 16'd0);
`endif
      reset = 1'b0; start = 1'b0;
      tick();
      check("abort_no_late_done", 16'(done), 16'd0);
      tick();
      check("abort_no_late_done2", 16'(done), 16'd0);
      check("abort_result_kept", result, 16'h0000);

      // three completed ops after the abort; first is accepted right away
      A = 8'd1; B = 8'd1; op = 3'b001; start = 1'b1;
      tick();
      check("post_add_done", 16'(done), 16'd1);
      check("post_add_result", result, 16'h0002);
      start = 1'b0; tick();
      A = 8'h0F; B = 8'h10; op = 3'b100; start = 1'b1;
      tick(); tick(); tick();
      check("post_mul_done", 16'(done), 16'd1);
      check("post_mul_result", result, 16'h00F0);
      start = 1'b0; tick();
      A = 8'hA5; B = 8'h0F; op = 3'b011; start = 1'b1;
      tick();
      check("post_xor_result", result, 16'h00AA);
      start = 1'b0; tick();
`ifdef TINYALU_OPCNT_EN
      check("opcnt_three", op_count, 16'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tinyalu_responder.md
Name: tinyalu_responder

Overview:
- Responder (DUT) end of the TinyALU start/done operation protocol; the BFM is the initiator.
- Samples operands A and B plus a 3-bit opcode when start is high.
- Computes add/and/xor in one cycle and multiply over a configurable multi-cycle path.
- Returns a 16-bit result with a one-cycle done pulse; the UVM testbench drives it through the existing BFM.

Parameters:
- MUL_LATENCY, 3, cycles from accepting a mul_op to asserting done; legal range 1..8.

Ports:
- clk      input   1   rising-edge clock
- reset    input   1   synchronous reset, active-high
- A        input   8   operand A, unsigned
- B        input   8   operand B, unsigned
- op       input   3   opcode: 000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op, 111 rst_op; 101/110 unused
- start    input   1   operation request; initiator holds it high until it sees done
- done     output  1   one-cycle completion pulse
- result   output  16  operation result

Behaviour:
- One clock (clk); reset is synchronous and active-high, sampled only on the rising edge of clk.
- All inputs are sampled on the rising edge of clk.
- Reset values: done=0, result=16'h0000, state=IDLE, multiply counter=0, captured operands=0.
- States:
  - IDLE: no operation in progress.
  - BUSY_MUL: multiply in progress.
  - WAIT_LOW: operation finished, waiting for start to drop.
- IDLE, start=1, op in {add, and, xor}:
  - Capture A, B, op at edge k; registered result and done=1 appear after edge k.
  - Go to WAIT_LOW.
- IDLE, start=1, op=mul:
  - Capture A and B at edge k.
  - If MUL_LATENCY=1: behave like a single-cycle op.
  - Otherwise: load counter with MUL_LATENCY-1 and go to BUSY_MUL.
- BUSY_MUL:
  - Decrement the counter each edge.
  - On the edge where the counter reaches 0, set result = captured A*B and done=1, then go to WAIT_LOW.
  - done is therefore high after edge k+MUL_LATENCY-1.
- WAIT_LOW:
  - done returns to 0 on the next edge.
  - Stay in WAIT_LOW while start=1; go to IDLE on the first edge with start=0.
  - A new operation needs at least one sampled start=0 between requests.
  - An initiator that holds start high after done does not retrigger.
- IDLE, start=1, op in {no_op, rst_op, 101, 110}:
  - No state change, done stays 0, result unchanged.
  - The initiator performs rst_op itself by asserting reset.
- Arithmetic:
  - add: 9-bit sum, zero-extended to 16 bits.
  - and/xor: 8-bit result, zero-extended.
  - mul: full 16-bit unsigned product; no overflow is possible.
- Changes to A, B, op or start while in BUSY_MUL are ignored; operands are latched at accept.
- result holds its value until the next done; it is only valid while done=1 and afterwards until the next accept.
- Reset mid-operation (any state): abort the pending operation, force reset values next edge, no done pulse.
- Reset has priority over start on the same edge.

Optional Feature:
- Macro TINYALU_OPCNT_EN.
- When defined:
  - Adds output port op_count[15:0], reset to 0.
  - op_count increments by 1 on every edge where done is asserted.
  - op_count wraps from 16'hFFFF to 16'h0000.
  - op_count is not incremented for no_op or for aborted operations.
- When undefined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Single-cycle add:
  - Stimulus: reset for 2 cycles, then add_op with A=8'hFF, B=8'h01, start held until done.
  - Required: done high exactly 1 cycle after accept edge, result=16'h0100, then done=0.
- Multiply latency:
  - Stimulus: mul_op A=8'hFF, B=8'hFF with MUL_LATENCY=3.
  - Required: done=1 only after edge k+2, result=16'hFE01; operands changed to A=0, B=0 mid-operation leave result unaffected.
- and/xor back-to-back:
  - Stimulus: and_op A=8'hF0, B=8'h3C, then xor_op with the same operands, start low for one edge between.
  - Required: results 16'h0030 then 16'h00CC, two done pulses.
- Start held after done:
  - Stimulus: add_op A=3, B=4, start kept high for 5 cycles after done.
  - Required: single done pulse, result=16'h0007; the next accept occurs only after start=0 is sampled.
- no_op and unused opcodes:
  - Stimulus: start=1 with op=000, then 101, then 110.
  - Required: done never asserts, result keeps previous value.
- Reset mid-multiply and op counter:
  - Stimulus: reset asserted at edge k+1 of a mul_op.
  - Required: no done, result=0, state IDLE, and with TINYALU_OPCNT_EN op_count=0; three completed ops afterwards give op_count=3.
